// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide sequencer for the EX stage.
// Runs a radix-2 shift-add multiply or restoring divide on operand
// magnitudes over 32 cycles, sign-corrects in a FIX cycle, then commits
// HI/LO. Raises stall while busy if EX presents another mul/div or HI/LO read.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hilo_rd,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]  count_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rem_neg_q;
  logic        div_zero_q;
  logic [31:0] rs_raw_q;
  logic [31:0] b_mag_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;

  logic        accept;
  logic        is_signed;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] acc_hi_nx;
  logic [31:0] acc_lo_nx;
  logic [63:0] prod_raw;
  logic [63:0] prod_fix;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  // A new operation is only taken from IDLE; flush kills a same-cycle start.
  assign accept    = (state_q == IDLE) && start && !flush;
  // op[0]=0 selects the signed variants (MULT, DIV).
  assign is_signed = !op[0];
  // Two's-complement negate of 0x80000000 yields 0x80000000, which is the
  // correct unsigned magnitude, so no special case is needed.
  assign rs_mag    = (is_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
  assign rt_mag    = (is_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

  assign busy  = (state_q != IDLE);
  assign stall = busy && (start || hilo_rd);

  // Per-iteration datapath: shift-add multiply step or restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    acc_hi_nx = acc_hi_q;
    acc_lo_nx = acc_lo_q;
    if (is_div_q) begin
      if (!div_diff[32]) begin
        acc_hi_nx = div_diff[31:0];
        acc_lo_nx = {acc_lo_q[30:0], 1'b1};
      end else begin
        acc_hi_nx = div_shift[31:0];
        acc_lo_nx = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      {acc_hi_nx, acc_lo_nx} = {mul_sum, acc_lo_q[31:1]};
    end
  end

  // Sign correction and divide-by-zero override of the final result.
  always_comb begin
    prod_raw = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? (~prod_raw + 64'd1) : prod_raw;
    hi_fix   = prod_fix[63:32];
    lo_fix   = prod_fix[31:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        hi_fix = rs_raw_q;
        lo_fix = 32'hFFFF_FFFF;
      end else begin
        hi_fix = rem_neg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
        lo_fix = neg_q     ? (~acc_lo_q + 32'd1) : acc_lo_q;
      end
    end
  end

  // Next-state logic: flush aborts CALC/FIX back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (flush)                 state_d = IDLE;
        else if (count_q == 5'd31) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture on accept, then one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 5'd0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rs_raw_q   <= 32'd0;
      b_mag_q    <= 32'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
    end else if (accept) begin
      count_q    <= 5'd0;
      is_div_q   <= op[1];
      neg_q      <= is_signed && (rs_data[31] ^ rt_data[31]);
      rem_neg_q  <= is_signed && rs_data[31];
      div_zero_q <= op[1] && (rt_data == 32'd0);
      rs_raw_q   <= rs_data;
      b_mag_q    <= rt_mag;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= rs_mag;
    end else if (state_q == CALC) begin
      count_q  <= count_q + 5'd1;
      acc_hi_q <= acc_hi_nx;
      acc_lo_q <= acc_lo_nx;
    end
  end

  // HI/LO commit and done pulse on the FIX->IDLE edge unless flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= (state_q == FIX) && !flush;
      if ((state_q == FIX) && !flush) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

endmodule
